// File: rtl/alu_pkg.sv
// Shared opcode encodings and issuer FSM state type for the ALU initiator.
package alu_pkg;

    localparam int ALU_ADD     = 0;
    localparam int ALU_SUB     = 1;
    localparam int ALU_AND     = 2;
    localparam int ALU_OR      = 3;
    localparam int ALU_NOT     = 4;
    localparam int ALU_SHL     = 5;
    localparam int ALU_SHR     = 6;
    localparam int ALU_OP_LAST = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        RESP = 2'd3
    } state_t;

endpackage

// File: rtl/alu_regfile.sv
// NREG x DATA_W register file: two asynchronous read ports, a host write port and a
// writeback port; writeback wins when both target the same entry in one cycle.
module alu_regfile #(
    parameter int DATA_W = 32,
    parameter int NREG   = 8,
    parameter int RA_W   = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [RA_W-1:0]   ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [RA_W-1:0]   rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic              hw_en,
    input  logic [RA_W-1:0]   hw_addr,
    input  logic [DATA_W-1:0] hw_data,
    input  logic              wb_en,
    input  logic [RA_W-1:0]   wb_addr,
    input  logic [DATA_W-1:0] wb_data
);

    logic [DATA_W-1:0] mem [NREG];

    assign ra_data = mem[ra_addr];
    assign rb_data = mem[rb_addr];

    // The writeback assignment comes last so it overrides a same-cycle host write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (hw_en) mem[hw_addr] <= hw_data;
            if (wb_en) mem[wb_addr] <= wb_data;
        end
    end

endmodule

// File: rtl/alu_op_issuer.sv
// ALU initiator: takes register-to-register commands, drives the external ALU, writes back
// and returns a response. Optional ALU_ERR_EN adds illegal-opcode detection and rsp_err.
module alu_op_issuer
    import alu_pkg::*;
#(
    parameter int  DATA_W = 32,
    parameter int  NREG   = 8,
    parameter int  OP_W   = 5,
    localparam int RA_W   = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [RA_W-1:0]   cmd_rd,
    input  logic [RA_W-1:0]   cmd_rs1,
    input  logic [RA_W-1:0]   cmd_rs2,
    input  logic              wr_en,
    input  logic [RA_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_opcode,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_zero,
    output logic              rsp_negative,
`ifdef ALU_ERR_EN
    output logic              rsp_err,
`endif
    output state_t            dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // rsp_valid and rsp_* stay asserted and unchanged until that transfer completes.

    state_t            state_q, state_d;
    logic [OP_W-1:0]   op_q;
    logic [RA_W-1:0]   rd_q, rs1_q, rs2_q;
    logic [DATA_W-1:0] rf_a, rf_b;
    logic              wb_en;

`ifdef ALU_ERR_EN
    logic err_q;
    logic op_illegal;

    assign op_illegal = int'(cmd_op) > ALU_OP_LAST;
    assign wb_en      = (state_q == EXEC) && !err_q;
`else
    assign wb_en      = (state_q == EXEC);
`endif

    alu_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG),
        .RA_W   (RA_W)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra_addr (rs1_q),
        .ra_data (rf_a),
        .rb_addr (rs2_q),
        .rb_data (rf_b),
        .hw_en   (wr_en),
        .hw_addr (wr_addr),
        .hw_data (wr_data),
        .wb_en   (wb_en),
        .wb_addr (rd_q),
        .wb_data (alu_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (cmd_valid) state_d = READ;
            READ: state_d = EXEC;
            EXEC: state_d = RESP;
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q         <= '0;
            rd_q         <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_opcode   <= '0;
            rsp_data     <= '0;
            rsp_zero     <= 1'b0;
            rsp_negative <= 1'b0;
`ifdef ALU_ERR_EN
            err_q        <= 1'b0;
            rsp_err      <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q  <= cmd_op;
                        rd_q  <= cmd_rd;
                        rs1_q <= cmd_rs1;
                        rs2_q <= cmd_rs2;
`ifdef ALU_ERR_EN
                        err_q <= op_illegal;
`endif
                    end
                end
                // Operands are sampled from the pre-edge register contents, so a host
                // write landing on this same edge is not seen.
                READ: begin
                    alu_a      <= rf_a;
                    alu_b      <= rf_b;
                    alu_opcode <= op_q;
                end
                EXEC: begin
`ifdef ALU_ERR_EN
                    if (err_q) begin
                        rsp_data     <= '0;
                        rsp_zero     <= 1'b1;
                        rsp_negative <= 1'b0;
                        rsp_err      <= 1'b1;
                    end else begin
                        rsp_data     <= alu_result;
                        rsp_zero     <= alu_zero;
                        rsp_negative <= alu_result[DATA_W-1];
                        rsp_err      <= 1'b0;
                    end
`else
                    rsp_data     <= alu_result;
                    rsp_zero     <= alu_zero;
                    rsp_negative <= alu_result[DATA_W-1];
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_issuer.sv
// Self-checking bench for alu_op_issuer: directed vector table, corner sequences and
// randomized commands against a register-file/ALU reference model. Honours ALU_ERR_EN.
module tb_alu_op_issuer;
    import alu_pkg::*;

    localparam int DATA_W = 32;
    localparam int NREG   = 8;
    localparam int OP_W   = 5;
    localparam int RA_W   = 3;
`ifdef ALU_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_op = '0;
    logic [RA_W-1:0]   cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
    logic              wr_en = 1'b0;
    logic [RA_W-1:0]   wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic [DATA_W-1:0] alu_a, alu_b, alu_result;
    logic [OP_W-1:0]   alu_opcode;
    logic              alu_zero;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_zero, rsp_negative;
    logic              rsp_err;
    state_t            dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [DATA_W-1:0] ref_rf [NREG];
    logic [DATA_W-1:0] exp_q[$];

    alu_op_issuer #(.DATA_W(DATA_W), .NREG(NREG), .OP_W(OP_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_rd       (cmd_rd),
        .cmd_rs1      (cmd_rs1),
        .cmd_rs2      (cmd_rs2),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_opcode   (alu_opcode),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_zero     (rsp_zero),
        .rsp_negative (rsp_negative),
`ifdef ALU_ERR_EN
        .rsp_err      (rsp_err),
`endif
        .dbg_state    (dbg_state)
    );

`ifndef ALU_ERR_EN
    assign rsp_err = 1'b0;
`endif

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference ALU arithmetic ----------------
    function automatic logic [DATA_W-1:0] ref_alu(input logic [OP_W-1:0] op,
                                                  input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        case (op)
            5'd0: return a + b;
            5'd1: return a - b;
            5'd2: return a & b;
            5'd3: return a | b;
            5'd4: return ~a;
            5'd5: return (b >= DATA_W) ? '0 : a << b;
            5'd6: return (b >= DATA_W) ? '0 : a >> b;
            default: return '0;
        endcase
    endfunction

    // Stand-in for the external combinational ALU.
    always_comb begin
        alu_result = ref_alu(alu_opcode, alu_a, alu_b);
        alu_zero   = (alu_result == '0);
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic preload(input logic [RA_W-1:0] addr, input logic [DATA_W-1:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        @(posedge clk);
        #1 wr_en = 1'b0;
        ref_rf[addr] = data;
        @(negedge clk);
    endtask

    // Runs one command from a negedge in IDLE. hw_phase 1/2 adds a host write during READ/EXEC.
    task automatic issue(input logic [OP_W-1:0] op, input logic [RA_W-1:0] rd,
                         input logic [RA_W-1:0] rs1, input logic [RA_W-1:0] rs2,
                         input int hold, input int hw_phase,
                         input logic [RA_W-1:0] hw_a, input logic [DATA_W-1:0] hw_d,
                         output logic [DATA_W-1:0] got_data,
                         output logic got_zero, output logic got_neg);
        logic [DATA_W-1:0] a, b, res, exp_d;
        logic illegal;
        a       = ref_rf[rs1];
        b       = ref_rf[rs2];
        illegal = (op > 5'd6);
        res     = ref_alu(op, a, b);
        exp_q.push_back(res);

        check("idle_cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        if (hw_phase == 1) begin wr_en = 1'b1; wr_addr = hw_a; wr_data = hw_d; end
        @(negedge clk);
        check("read_rsp_valid", rsp_valid, 0);
        check("read_cmd_ready", cmd_ready, 0);
        check("read_state", dbg_state, READ);
        @(posedge clk);
        #1 wr_en = 1'b0;
        if (hw_phase == 2) begin wr_en = 1'b1; wr_addr = hw_a; wr_data = hw_d; end
        @(negedge clk);
        check("exec_alu_a", alu_a, a);
        check("exec_alu_b", alu_b, b);
        check("exec_alu_opcode", alu_opcode, op);
        check("exec_rsp_valid", rsp_valid, 0);
        @(posedge clk);
        #1 wr_en = 1'b0;
        if (hw_phase != 0) ref_rf[hw_a] = hw_d;
        if (!(ERR_EN && illegal)) ref_rf[rd] = res;
        @(negedge clk);
        check("resp_rsp_valid", rsp_valid, 1);
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
            exp_d = '0;
        end else begin
            exp_d = exp_q.pop_front();
        end
        check("rsp_data", rsp_data, exp_d);
        check("rsp_zero", rsp_zero, exp_d == '0);
        check("rsp_negative", rsp_negative, exp_d[DATA_W-1]);
        check("rsp_err", rsp_err, ERR_EN && illegal);
        got_data = rsp_data; got_zero = rsp_zero; got_neg = rsp_negative;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("hold_rsp_valid", rsp_valid, 1);
            check("hold_cmd_ready", cmd_ready, 0);
            check("hold_rsp_data", rsp_data, exp_d);
            check("hold_rsp_zero", rsp_zero, exp_d == '0);
            check("hold_rsp_negative", rsp_negative, exp_d[DATA_W-1]);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check("after_rsp_valid", rsp_valid, 0);
        check("after_cmd_ready", cmd_ready, 1);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic              pre;
        logic [RA_W-1:0]   pa1;
        logic [DATA_W-1:0] pv1;
        logic [RA_W-1:0]   pa2;
        logic [DATA_W-1:0] pv2;
        logic [OP_W-1:0]   op;
        logic [RA_W-1:0]   rd, rs1, rs2;
        int                hold;
        logic [DATA_W-1:0] exp_data;
        logic              exp_zero;
        logic              exp_neg;
    } vec_t;

    localparam int NVEC = 10;
    vec_t tbl [NVEC];

    initial begin
        logic [DATA_W-1:0] d;
        logic z, n;
        logic [DATA_W-1:0] r7_exp;

        for (int i = 0; i < NREG; i++) ref_rf[i] = '0;
        r7_exp = ERR_EN ? 32'h1234 : 32'h0;

        tbl[0] = '{1'b1, 3'd1, 32'd5, 3'd2, 32'd3,  5'd0, 3'd3, 3'd1, 3'd2, 0, 32'd8, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 3'd0, 32'd0, 3'd0, 32'd0,  5'd3, 3'd3, 3'd3, 3'd3, 0, 32'd8, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 3'd0, 32'd0, 3'd0, 32'd0,  5'd1, 3'd4, 3'd2, 3'd1, 0, 32'hFFFF_FFFE, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 3'd0, 32'd0, 3'd0, 32'd0,  5'd1, 3'd5, 3'd1, 3'd1, 0, 32'd0, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 3'd0, 32'd0, 3'd0, 32'd0,  5'd2, 3'd6, 3'd1, 3'd2, 0, 32'd1, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 3'd0, 32'd0, 3'd0, 32'd0,  5'd4, 3'd7, 3'd2, 3'd0, 5, 32'hFFFF_FFFC, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 3'd1, 32'd1, 3'd2, 32'd31, 5'd5, 3'd6, 3'd1, 3'd2, 0, 32'h8000_0000, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 3'd0, 32'd0, 3'd0, 32'd0,  5'd6, 3'd5, 3'd6, 3'd2, 0, 32'd1, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 3'd7, 32'h1234, 3'd7, 32'h1234, 5'h08, 3'd7, 3'd1, 3'd2, 0, 32'd0, 1'b1, 1'b0};
        tbl[9] = '{1'b0, 3'd0, 32'd0, 3'd0, 32'd0,  5'd3, 3'd7, 3'd7, 3'd7, 0, r7_exp, r7_exp == 0, 1'b0};

        // ---------------- reset ----------------
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_opcode", alu_opcode, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_zero", rsp_zero, 0);
        check("rst_rsp_negative", rsp_negative, 0);
        check("rst_rsp_err", rsp_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- table ----------------
        for (int i = 0; i < NVEC; i++) begin
            if (tbl[i].pre) begin
                preload(tbl[i].pa1, tbl[i].pv1);
                preload(tbl[i].pa2, tbl[i].pv2);
            end
            issue(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].hold, 0, '0, '0, d, z, n);
            check($sformatf("vec%0d_data", i), d, tbl[i].exp_data);
            check($sformatf("vec%0d_zero", i), z, tbl[i].exp_zero);
            check($sformatf("vec%0d_neg", i), n, tbl[i].exp_neg);
        end

        // ---------------- host write vs. operand read / writeback ----------------
        preload(3'd1, 32'd10);
        preload(3'd2, 32'd20);
        issue(5'd0, 3'd3, 3'd1, 3'd2, 0, 1, 3'd1, 32'd100, d, z, n);
        check("rbw_old_operand", d, 32'd30);
        issue(5'd3, 3'd1, 3'd1, 3'd1, 0, 0, '0, '0, d, z, n);
        check("rbw_new_value", d, 32'd100);
        issue(5'd0, 3'd3, 3'd1, 3'd2, 0, 2, 3'd3, 32'hDEAD, d, z, n);
        issue(5'd3, 3'd3, 3'd3, 3'd3, 0, 0, '0, '0, d, z, n);
        check("collision_wb_wins", d, 32'd120);
        issue(5'd1, 3'd5, 3'd2, 3'd1, 0, 2, 3'd4, 32'h77, d, z, n);
        issue(5'd3, 3'd4, 3'd4, 3'd4, 0, 0, '0, '0, d, z, n);
        check("exec_host_write_other", d, 32'h77);

        // ---------------- reset during EXEC ----------------
        preload(3'd1, 32'd5);
        preload(3'd2, 32'd3);
        cmd_valid = 1'b1; cmd_op = 5'd0; cmd_rd = 3'd3; cmd_rs1 = 3'd1; cmd_rs2 = 3'd2;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(posedge clk);
        #1 check("pre_abort_state", dbg_state, EXEC);
        rst_n = 1'b0;
        #1;
        check("abort_cmd_ready", cmd_ready, 1);
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_alu_a", alu_a, 0);
        check("abort_alu_b", alu_b, 0);
        check("abort_rsp_data", rsp_data, 0);
        check("abort_rsp_zero", rsp_zero, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NREG; i++) ref_rf[i] = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("post_abort_no_rsp", rsp_valid, 0);
        end
        for (int i = 0; i < NREG; i++) begin
            issue(5'd3, RA_W'(i), RA_W'(i), RA_W'(i), 0, 0, '0, '0, d, z, n);
            check($sformatf("post_abort_r%0d", i), d, 0);
        end

        // ---------------- randomized commands ----------------
        for (int it = 0; it < 60; it++) begin
            logic [OP_W-1:0] op;
            logic [DATA_W-1:0] v;
            if ($urandom_range(0, 2) == 0) begin
                v = ($urandom_range(0, 1) == 0) ? DATA_W'($urandom_range(0, 40)) : DATA_W'($urandom);
                preload(RA_W'($urandom_range(0, NREG-1)), v);
            end
            op = ($urandom_range(0, 9) == 0) ? OP_W'($urandom_range(7, 31)) : OP_W'($urandom_range(0, 6));
            issue(op, RA_W'($urandom_range(0, NREG-1)), RA_W'($urandom_range(0, NREG-1)),
                  RA_W'($urandom_range(0, NREG-1)), $urandom_range(0, 2), $urandom_range(0, 2),
                  RA_W'($urandom_range(0, NREG-1)), DATA_W'($urandom), d, z, n);
        end
        for (int i = 0; i < NREG; i++) begin
            logic [DATA_W-1:0] e;
            e = ref_rf[i];
            issue(5'd3, RA_W'(i), RA_W'(i), RA_W'(i), 0, 0, '0, '0, d, z, n);
            check($sformatf("final_r%0d", i), d, e);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
